// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store bus engine: lane strobes, store positioning, load extend/merge
// Optional MEM_ACCESS_MISALIGN_EXC_EN: adds addr_err, misaligned normal half/word skip the bus.
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_load,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic [1:0]        req_kind,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W-1:0] req_rt_old,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] Address,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [DATA_W-1:0] Write_data,
  output logic [3:0]        Write_strb,
  input  logic              Mem_Req_Ack,
  input  logic [DATA_W-1:0] Read_data,
  input  logic              Read_data_Valid,
  output logic              Read_data_Ack
`ifdef MEM_ACCESS_MISALIGN_EXC_EN
  ,
  output logic              addr_err
`endif
);

  localparam logic [1:0] SZ_BYTE    = 2'd0;
  localparam logic [1:0] SZ_HALF    = 2'd1;
  localparam logic [1:0] KIND_LEFT  = 2'd1;
  localparam logic [1:0] KIND_RIGHT = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RDW, S_RESP} state_t;

  state_t              state_q;
  logic                req_ready_q;
  logic                resp_valid_q;
  logic [DATA_W-1:0]   resp_rdata_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                mem_read_q;
  logic                mem_write_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [3:0]          strb_q;
  logic                rd_ack_q;
  logic                lat_load_q;
  logic [1:0]          lat_size_q;
  logic [1:0]          lat_kind_q;
  logic                lat_uns_q;
  logic [1:0]          lat_a_q;
  logic [DATA_W-1:0]   lat_rt_q;
`ifdef MEM_ACCESS_MISALIGN_EXC_EN
  logic                addr_err_q;
`endif

  logic [1:0]        a_in;
  logic              eff_load;
  logic              eff_store;
  logic              misalign;
  logic [3:0]        st_strb;
  logic [DATA_W-1:0] st_data;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_result;

  assign a_in      = req_addr[1:0];
  assign eff_load  = req_load;
  assign eff_store = req_store & ~req_load;

`ifdef MEM_ACCESS_MISALIGN_EXC_EN
  assign misalign = (eff_load | eff_store) &&
                    (req_kind != KIND_LEFT) && (req_kind != KIND_RIGHT) &&
                    (((req_size == SZ_HALF) && a_in[0]) || (req_size[1] && (a_in != 2'd0)));
`else
  assign misalign = 1'b0;
`endif

  // Store lane placement from the live request, captured at accept.
  always_comb begin
    st_strb = 4'b1111;
    st_data = req_wdata;
    case (req_kind)
      KIND_LEFT: begin
        st_strb = 4'b1111 >> ~a_in;
        st_data = req_wdata >> {~a_in, 3'b000};
      end
      KIND_RIGHT: begin
        st_strb = 4'b1111 << a_in;
        st_data = req_wdata << {a_in, 3'b000};
      end
      default: begin
        case (req_size)
          SZ_BYTE: begin
            st_strb = 4'b0001 << a_in;
            st_data = {4{req_wdata[7:0]}};
          end
          SZ_HALF: begin
            st_strb = a_in[1] ? 4'b1100 : 4'b0011;
            st_data = {2{req_wdata[15:0]}};
          end
          default: ;
        endcase
      end
    endcase
  end

  // Load alignment uses the latched request fields and the incoming memory word.
  always_comb begin
    ld_byte   = Read_data[{lat_a_q, 3'b000} +: 8];
    ld_half   = lat_a_q[1] ? Read_data[31:16] : Read_data[15:0];
    ld_result = Read_data;
    case (lat_kind_q)
      KIND_LEFT:
        ld_result = (Read_data << {~lat_a_q, 3'b000}) |
                    (lat_rt_q & ~(32'hFFFF_FFFF << {~lat_a_q, 3'b000}));
      KIND_RIGHT:
        ld_result = (Read_data >> {lat_a_q, 3'b000}) |
                    (lat_rt_q & ~(32'hFFFF_FFFF >> {lat_a_q, 3'b000}));
      default: begin
        case (lat_size_q)
          SZ_BYTE: ld_result = {{24{~lat_uns_q & ld_byte[7]}}, ld_byte};
          SZ_HALF: ld_result = {{16{~lat_uns_q & ld_half[15]}}, ld_half};
          default: ;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      addr_q       <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      wdata_q      <= '0;
      strb_q       <= 4'b0000;
      rd_ack_q     <= 1'b0;
      lat_load_q   <= 1'b0;
      lat_size_q   <= 2'd0;
      lat_kind_q   <= 2'd0;
      lat_uns_q    <= 1'b0;
      lat_a_q      <= 2'd0;
      lat_rt_q     <= '0;
`ifdef MEM_ACCESS_MISALIGN_EXC_EN
      addr_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
            lat_load_q  <= eff_load;
            lat_size_q  <= req_size;
            lat_kind_q  <= req_kind;
            lat_uns_q   <= req_unsigned;
            lat_a_q     <= a_in;
            lat_rt_q    <= req_rt_old;
            addr_q      <= {req_addr[ADDR_W-1:2], 2'b00};
            if ((eff_load | eff_store) && !misalign) begin
              state_q     <= S_REQ;
              mem_read_q  <= eff_load;
              mem_write_q <= eff_store;
              strb_q      <= eff_store ? st_strb : 4'b0000;
              wdata_q     <= eff_store ? st_data : '0;
            end else begin
              // No bus traffic: complete immediately with a zero result.
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= '0;
              strb_q       <= 4'b0000;
              wdata_q      <= '0;
`ifdef MEM_ACCESS_MISALIGN_EXC_EN
              addr_err_q   <= misalign;
`endif
            end
          end
        end
        S_REQ: begin
          if (Mem_Req_Ack) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            strb_q      <= 4'b0000;
            if (lat_load_q) begin
              state_q  <= S_RDW;
              rd_ack_q <= 1'b1;
            end else begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= '0;
            end
          end
        end
        S_RDW: begin
          if (Read_data_Valid) begin
            state_q      <= S_RESP;
            rd_ack_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= ld_result;
          end
        end
        S_RESP: begin
          state_q      <= S_IDLE;
          resp_valid_q <= 1'b0;
          resp_rdata_q <= '0;
          req_ready_q  <= 1'b1;
`ifdef MEM_ACCESS_MISALIGN_EXC_EN
          addr_err_q   <= 1'b0;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign Address       = addr_q;
  assign MemRead       = mem_read_q;
  assign MemWrite      = mem_write_q;
  assign Write_data    = wdata_q;
  assign Write_strb    = strb_q;
  assign Read_data_Ack = rd_ack_q;
`ifdef MEM_ACCESS_MISALIGN_EXC_EN
  assign addr_err      = addr_err_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench: random load/store traffic against a byte-level model
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid, req_ready, req_load, req_store, req_unsigned;
  logic [1:0]  req_size, req_kind;
  logic [31:0] req_addr, req_wdata, req_rt_old;
  logic        resp_valid;
  logic [31:0] resp_rdata, Address, Write_data, Read_data;
  logic        MemRead, MemWrite, Mem_Req_Ack, Read_data_Valid, Read_data_Ack;
  logic [3:0]  Write_strb;
`ifdef MEM_ACCESS_MISALIGN_EXC_EN
  logic        addr_err;
`endif

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_access_unit dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_load(req_load), .req_store(req_store), .req_size(req_size), .req_kind(req_kind),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rt_old(req_rt_old), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .Address(Address), .MemRead(MemRead), .MemWrite(MemWrite), .Write_data(Write_data),
    .Write_strb(Write_strb), .Mem_Req_Ack(Mem_Req_Ack), .Read_data(Read_data),
    .Read_data_Valid(Read_data_Valid), .Read_data_Ack(Read_data_Ack)
`ifdef MEM_ACCESS_MISALIGN_EXC_EN
    , .addr_err(addr_err)
`endif
  );

  typedef struct {
    bit          is_read;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
    logic [31:0] rword;
    int          ack_dly;
    int          rd_dly;
  } bus_t;

  typedef struct {
    logic [31:0] rdata;
    bit          aerr;
    int unsigned due;
  } rsp_t;

  bus_t bus_q[$];
  rsp_t rsp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int i);
    return w[8*i +: 8];
  endfunction

  // Which lanes a store touches and which source byte lands in each lane.
  task automatic model_store(input int sz, input int k, input int a, input logic [31:0] rt,
                             output logic [3:0] strb, output logic [31:0] data);
    for (int i = 0; i < 4; i++) begin
      strb[i] = 1'b0;
      data[8*i +: 8] = 8'h00;
      if (k == 1) begin
        strb[i] = (i <= a);
        if (i + 3 - a < 4) data[8*i +: 8] = byte_of(rt, i + 3 - a);
      end else if (k == 2) begin
        strb[i] = (i >= a);
        if (i >= a) data[8*i +: 8] = byte_of(rt, i - a);
      end else if (sz == 0) begin
        strb[i] = (i == a);
        data[8*i +: 8] = byte_of(rt, 0);
      end else if (sz == 1) begin
        strb[i] = ((i / 2) == (a / 2));
        data[8*i +: 8] = byte_of(rt, i % 2);
      end else begin
        strb[i] = 1'b1;
        data[8*i +: 8] = byte_of(rt, i);
      end
    end
  endtask

  function automatic logic [31:0] model_load(input int sz, input int k, input bit uns, input int a,
                                             input logic [31:0] m, input logic [31:0] rt);
    logic [31:0] r;
    int v;
    r = m;
    if (k == 1) begin
      for (int i = 0; i < 4; i++)
        r[8*i +: 8] = (i >= 3 - a) ? byte_of(m, i - (3 - a)) : byte_of(rt, i);
    end else if (k == 2) begin
      for (int i = 0; i < 4; i++)
        r[8*i +: 8] = (i < 4 - a) ? byte_of(m, i + a) : byte_of(rt, i);
    end else if (sz == 0) begin
      v = byte_of(m, a);
      if (!uns && v >= 128) v -= 256;
      r = v;
    end else if (sz == 1) begin
      v = m[16*(a/2) +: 16];
      if (!uns && v >= 32768) v -= 65536;
      r = v;
    end
    return r;
  endfunction

  task automatic issue(input bit ld, input bit st, input logic [1:0] size, input logic [1:0] kind,
                       input bit uns, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rt, input logic [31:0] mword,
                       input int ack_dly, input int rd_dly);
    bus_t b;
    rsp_t r;
    bit   eff_ld, eff_st, mis;
    int   a, k, sz, n;
    a      = int'(addr[1:0]);
    k      = (kind == 2'd3) ? 0 : int'(kind);
    sz     = (size == 2'd3) ? 2 : int'(size);
    eff_ld = ld;
    eff_st = st && !ld;
    mis    = 1'b0;
`ifdef MEM_ACCESS_MISALIGN_EXC_EN
    mis = (eff_ld || eff_st) && (k == 0) && ((sz == 1 && (a % 2) == 1) || (sz == 2 && a != 0));
`endif
    repeat ($urandom_range(0, 2)) @(negedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 100);
    check("req_ready_wait", req_ready, 1);

    r.aerr  = mis;
    r.rdata = 32'h0;
    if ((eff_ld || eff_st) && !mis) begin
      b.is_read = eff_ld;
      b.addr    = {addr[31:2], 2'b00};
      b.rword   = mword;
      b.ack_dly = ack_dly;
      b.rd_dly  = rd_dly;
      model_store(sz, k, a, wdata, b.strb, b.data);
      if (eff_ld) r.rdata = model_load(sz, k, uns, a, mword, rt);
      r.due = cyc + (eff_ld ? 3 + ack_dly + rd_dly : 2 + ack_dly);
      bus_q.push_back(b);
    end else begin
      r.due = cyc + 1;
    end
    rsp_q.push_back(r);

    req_load = ld; req_store = st; req_size = size; req_kind = kind; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_rt_old = rt;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr = $urandom; req_wdata = $urandom; req_rt_old = $urandom;
    req_size = 2'($urandom); req_kind = 2'($urandom); req_unsigned = 1'($urandom);
  endtask

  task automatic monitor_loop();
    rsp_t r;
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        if (rsp_q.size() == 0) begin
          check("resp_unexpected", resp_valid, 0);
        end else begin
          r = rsp_q.pop_front();
          check("resp_rdata", resp_rdata, r.rdata);
          check("resp_cycle", cyc, r.due);
`ifdef MEM_ACCESS_MISALIGN_EXC_EN
          check("addr_err", addr_err, r.aerr);
`endif
        end
      end
    end
  endtask

  task automatic responder_loop();
    bus_t b;
    int   n;
    forever begin
      @(negedge clk);
      if (MemRead || MemWrite) begin
        if (bus_q.size() == 0) begin
          check("bus_unexpected", MemRead | MemWrite, 0);
        end else begin
          b = bus_q.pop_front();
          check("bus_read", MemRead, b.is_read);
          check("bus_write", MemWrite, !b.is_read);
          check("bus_addr", Address, b.addr);
          if (!b.is_read) begin
            check("bus_strb", Write_strb, b.strb);
            check("bus_wdata", Write_data, b.data);
          end
          // Stray read-data strobes while the request is pending must be ignored.
          for (int i = 0; i < b.ack_dly; i++) begin
            Read_data_Valid = 1'($urandom);
            Read_data = $urandom;
            @(negedge clk);
          end
          Read_data_Valid = 1'b0;
          check("bus_hold_dir", {MemRead, MemWrite}, {b.is_read, !b.is_read});
          check("bus_hold_addr", Address, b.addr);
          Mem_Req_Ack = 1'b1;
          @(posedge clk);
          #1;
          Mem_Req_Ack = 1'b0;
          if (b.is_read) begin
            n = 0;
            do begin
              @(negedge clk);
              n++;
            end while (!Read_data_Ack && n < 100);
            check("rd_ack_wait", Read_data_Ack, 1);
            repeat (b.rd_dly) @(negedge clk);
            Read_data = b.rword;
            Read_data_Valid = 1'b1;
            @(posedge clk);
            #1;
            Read_data_Valid = 1'b0;
            Read_data = $urandom;
          end
        end
      end
    end
  endtask

  initial begin
    int n, op;
    resetn = 1'b0; req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0; req_size = 2'd0;
    req_kind = 2'd0; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; req_rt_old = '0;
    Mem_Req_Ack = 1'b0; Read_data = '0; Read_data_Valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_memread", MemRead, 0);
    check("rst_memwrite", MemWrite, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_rd_ack", Read_data_Ack, 0);
    check("rst_strb", Write_strb, 0);
    check("rst_address", Address, 0);
    resetn = 1'b1;
    @(negedge clk);
    check("post_rst_ready", req_ready, 1);

    // Reset while waiting for read data: everything drops, late handshakes ignored.
    req_load = 1'b1; req_size = 2'd2; req_addr = 32'h500; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_load = 1'b0;
    @(negedge clk);
    check("abort_memread", MemRead, 1);
    Mem_Req_Ack = 1'b1;
    @(posedge clk);
    #1;
    Mem_Req_Ack = 1'b0;
    @(negedge clk);
    check("abort_in_rdw", Read_data_Ack, 1);
    resetn = 1'b0;
    #1;
    check("abort_rd_ack", Read_data_Ack, 0);
    check("abort_memread_low", MemRead, 0);
    @(negedge clk);
    resetn = 1'b1;
    Read_data_Valid = 1'b1; Read_data = 32'hDEADBEEF; Mem_Req_Ack = 1'b1;
    @(negedge clk);
    check("abort_no_resp", resp_valid, 0);
    check("abort_ready", req_ready, 1);
    check("abort_no_read", MemRead, 0);
    Read_data_Valid = 1'b0; Mem_Req_Ack = 1'b0;
    @(negedge clk);
    check("abort_no_resp2", resp_valid, 0);

    fork
      monitor_loop();
      responder_loop();
    join_none

    issue(0, 1, 2'd0, 2'd0, 0, 32'h103, 32'h0000_00AB, 32'h0, 32'h0, 2, 0);
    issue(1, 0, 2'd0, 2'd0, 0, 32'h102, 32'h0, 32'h0, 32'h1280_FF34, 1, 1);
    issue(1, 0, 2'd0, 2'd0, 1, 32'h102, 32'h0, 32'h0, 32'h1280_FF34, 0, 0);
    issue(1, 0, 2'd2, 2'd1, 0, 32'h201, 32'h0, 32'h1122_3344, 32'hAABB_CCDD, 0, 2);
    issue(1, 0, 2'd2, 2'd2, 0, 32'h201, 32'h0, 32'h1122_3344, 32'hAABB_CCDD, 3, 0);
    issue(0, 1, 2'd2, 2'd2, 0, 32'h302, 32'h1122_3344, 32'h0, 32'h0, 0, 0);
    issue(0, 1, 2'd2, 2'd1, 0, 32'h300, 32'h1122_3344, 32'h0, 32'h0, 1, 0);
    issue(0, 0, 2'd2, 2'd0, 0, 32'h104, 32'h1, 32'h2, 32'h3, 0, 0);
    issue(1, 1, 2'd1, 2'd0, 0, 32'h106, 32'h1, 32'h2, 32'h8001_7FFF, 0, 0);
    issue(1, 0, 2'd2, 2'd0, 0, 32'h401, 32'h0, 32'h0, 32'hCAFE_F00D, 0, 0);
    issue(0, 1, 2'd1, 2'd0, 0, 32'h403, 32'hBEEF, 32'h0, 32'h0, 0, 0);

    for (int t = 0; t < 250; t++) begin
      op = $urandom_range(0, 19);
      issue(op < 10, (op >= 9 && op < 19), 2'($urandom), 2'($urandom), 1'($urandom),
            $urandom, $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    n = 0;
    while ((rsp_q.size() != 0 || bus_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("drain_resp", rsp_q.size(), 0);
    check("drain_bus", bus_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
